icache_direct: RTL and testbench

- Direct-mapped instruction cache between the instruction fetcher and MemController.
- Serves 32-bit instruction fetches from the fetcher and returns hits with 1-cycle latency.
- On a miss, requests one 2-instruction block (64 bits) from MemController, fills the line, then answers the fetcher.
- Holds the miss request stable until MemController completes it; a pipeline clear drops the pending answer but still completes the fill.

---
 rtl/cpu_defs.sv | 17 +
 rtl/icache_array.sv | 49 ++++
 rtl/icache_direct.sv | 104 ++++++++++
 tb/tb_icache_direct.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/cpu_defs.sv
// rtl/cpu_defs.sv - shared cache geometry parameters and state encodings
package cpu_defs;

    localparam int ADDR_WIDTH  = 32;
    localparam int BLOCK_WIDTH = 1;
    localparam int BLOCK_SIZE  = 1 << BLOCK_WIDTH;
    localparam int CACHE_WIDTH = 8;
    localparam int BLOCK_NUM   = 1 << CACHE_WIDTH;
    localparam int TAG_WIDTH   = ADDR_WIDTH - CACHE_WIDTH - BLOCK_WIDTH - 2;
    localparam int LINE_WIDTH  = 32 * BLOCK_SIZE;

    typedef enum logic {
        IC_IDLE = 1'b0,
        IC_MISS = 1'b1
    } ic_state_t;

endpackage

// File: rtl/icache_array.sv
// rtl/icache_array.sv - valid/tag/data storage with combinational lookup and write-on-fill
//
// Ports:
//   Sys_clk, Sys_rst   clock, async active-low reset (clears valid bits only)
//   rd_index/rd_tag/rd_word  lookup address fields
//   rd_hit, rd_inst    lookup result (combinational)
//   wr_en, wr_index, wr_tag, wr_line  line fill
import cpu_defs::*;

module icache_array (
    input  logic                   Sys_clk,
    input  logic                   Sys_rst,
    input  logic [CACHE_WIDTH-1:0] rd_index,
    input  logic [TAG_WIDTH-1:0]   rd_tag,
    input  logic                   rd_word,
    output logic                   rd_hit,
    output logic [31:0]            rd_inst,
    input  logic                   wr_en,
    input  logic [CACHE_WIDTH-1:0] wr_index,
    input  logic [TAG_WIDTH-1:0]   wr_tag,
    input  logic [LINE_WIDTH-1:0]  wr_line
);

    logic [BLOCK_NUM-1:0]  valid_q;
    logic [TAG_WIDTH-1:0]  tag_mem  [BLOCK_NUM];
    logic [LINE_WIDTH-1:0] data_mem [BLOCK_NUM];
    logic [LINE_WIDTH-1:0] rd_line;

    always_ff @(posedge Sys_clk or negedge Sys_rst) begin
        if (!Sys_rst) begin
            valid_q <= '0;
        end else if (wr_en) begin
            valid_q[wr_index] <= 1'b1;
        end
    end

    // Tag and data contents are don't-care until the valid bit is set.
    always_ff @(posedge Sys_clk) begin
        if (wr_en) begin
            tag_mem[wr_index]  <= wr_tag;
            data_mem[wr_index] <= wr_line;
        end
    end

    assign rd_line = data_mem[rd_index];
    assign rd_hit  = valid_q[rd_index] && (tag_mem[rd_index] == rd_tag);
    assign rd_inst = rd_word ? rd_line[63:32] : rd_line[31:0];

endmodule

// File: rtl/icache_direct.sv
// rtl/icache_direct.sv - direct-mapped instruction cache between fetcher and memory controller
//
// Ports:
//   Sys_clk, Sys_rst, Sys_rdy   clock, async active-low reset, global enable
//   Clear                       pipeline flush, drops any pending fetch answer
//   IFIC_en, IFIC_addr          fetch request (level, held until ICIF_en)
//   ICIF_en, ICIF_inst          one-cycle answer pulse and instruction
//   ICMC_en, ICMC_addr          block read request to memory controller (level)
//   MCIC_en, MCIC_block         one-cycle block return from memory controller
import cpu_defs::*;

module icache_direct (
    input  logic                  Sys_clk,
    input  logic                  Sys_rst,
    input  logic                  Sys_rdy,
    input  logic                  Clear,
    input  logic                  IFIC_en,
    input  logic [ADDR_WIDTH-1:0] IFIC_addr,
    output logic                  ICIF_en,
    output logic [31:0]           ICIF_inst,
    output logic                  ICMC_en,
    output logic [ADDR_WIDTH-1:0] ICMC_addr,
    input  logic                  MCIC_en,
    input  logic [LINE_WIDTH-1:0] MCIC_block
);

    ic_state_t             state;
    logic                  drop;
    logic [ADDR_WIDTH-1:0] req_addr;

    logic                  hit;
    logic [31:0]           hit_inst;
    logic                  fill;
    logic [31:0]           fill_inst;
    logic                  unused_addr_bits;

    // Byte offset within an instruction is irrelevant for aligned fetches.
    assign unused_addr_bits = ^{IFIC_addr[1:0], req_addr[1:0]};

    assign fill      = Sys_rdy && (state == IC_MISS) && MCIC_en;
    assign fill_inst = req_addr[2] ? MCIC_block[63:32] : MCIC_block[31:0];

    icache_array u_array (
        .Sys_clk  (Sys_clk),
        .Sys_rst  (Sys_rst),
        .rd_index (IFIC_addr[10:3]),
        .rd_tag   (IFIC_addr[31:11]),
        .rd_word  (IFIC_addr[2]),
        .rd_hit   (hit),
        .rd_inst  (hit_inst),
        .wr_en    (fill),
        .wr_index (req_addr[10:3]),
        .wr_tag   (req_addr[31:11]),
        .wr_line  (MCIC_block)
    );

    always_ff @(posedge Sys_clk or negedge Sys_rst) begin
        if (!Sys_rst) begin
            state     <= IC_IDLE;
            drop      <= 1'b0;
            req_addr  <= '0;
            ICIF_en   <= 1'b0;
            ICIF_inst <= '0;
            ICMC_en   <= 1'b0;
            ICMC_addr <= '0;
        end else if (Sys_rdy) begin
            ICIF_en <= 1'b0;
            case (state)
                IC_IDLE: begin
                    // While ICIF_en is high the fetcher is still presenting the
                    // request just answered; serving it again would double-answer.
                    if (IFIC_en && !ICIF_en && !Clear) begin
                        if (hit) begin
                            ICIF_inst <= hit_inst;
                            ICIF_en   <= 1'b1;
                        end else begin
                            req_addr  <= IFIC_addr;
                            ICMC_en   <= 1'b1;
                            ICMC_addr <= {IFIC_addr[ADDR_WIDTH-1:3], 3'b000};
                            state     <= IC_MISS;
                        end
                    end
                end
                IC_MISS: begin
                    // Memory reads cannot be aborted: a flush only suppresses the answer.
                    if (Clear) begin
                        drop <= 1'b1;
                    end
                    if (MCIC_en) begin
                        ICMC_en <= 1'b0;
                        drop    <= 1'b0;
                        state   <= IC_IDLE;
                        if (!drop && !Clear) begin
                            ICIF_inst <= fill_inst;
                            ICIF_en   <= 1'b1;
                        end
                    end
                end
                default: state <= IC_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_icache_direct.sv
// tb/tb_icache_direct.sv - self-checking bench for icache_direct
`timescale 1ns/1ps
module tb_icache_direct;

    logic        Sys_clk;
    logic        Sys_rst;
    logic        Sys_rdy;
    logic        Clear;
    logic        IFIC_en;
    logic [31:0] IFIC_addr;
    logic        ICIF_en;
    logic [31:0] ICIF_inst;
    logic        ICMC_en;
    logic [31:0] ICMC_addr;
    logic        MCIC_en;
    logic [63:0] MCIC_block;

    int checks;
    int errors;

    typedef struct {
        logic [31:0] addr;
        logic        miss;
        logic [63:0] block;
        logic [31:0] mc_addr;
        logic [31:0] inst;
    } vec_t;

    vec_t vecs [10];

    icache_direct dut (
        .Sys_clk    (Sys_clk),
        .Sys_rst    (Sys_rst),
        .Sys_rdy    (Sys_rdy),
        .Clear      (Clear),
        .IFIC_en    (IFIC_en),
        .IFIC_addr  (IFIC_addr),
        .ICIF_en    (ICIF_en),
        .ICIF_inst  (ICIF_inst),
        .ICMC_en    (ICMC_en),
        .ICMC_addr  (ICMC_addr),
        .MCIC_en    (MCIC_en),
        .MCIC_block (MCIC_block)
    );

    initial Sys_clk = 1'b0;
    always #5 Sys_clk = ~Sys_clk;

    task automatic step();
        @(posedge Sys_clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic fetch(input string name, input vec_t v);
        IFIC_addr = v.addr;
        IFIC_en   = 1'b1;
        step();
        if (v.miss) begin
            check({name, " req_en"},   {31'd0, ICMC_en}, 32'd1);
            check({name, " req_addr"}, ICMC_addr, v.mc_addr);
            check({name, " no_early"}, {31'd0, ICIF_en}, 32'd0);
            step();
            check({name, " hold_en"},   {31'd0, ICMC_en}, 32'd1);
            check({name, " hold_addr"}, ICMC_addr, v.mc_addr);
            MCIC_block = v.block;
            MCIC_en    = 1'b1;
            step();
            MCIC_en    = 1'b0;
        end
        check({name, " ans_en"},  {31'd0, ICIF_en}, 32'd1);
        check({name, " ans_inst"}, ICIF_inst, v.inst);
        check({name, " mc_idle"}, {31'd0, ICMC_en}, 32'd0);
        IFIC_en = 1'b0;
        step();
        check({name, " pulse_end"}, {31'd0, ICIF_en}, 32'd0);
    endtask

    initial begin
        checks = 0;
        errors = 0;

        vecs[0] = '{32'h0000_1004, 1'b1, 64'h11223344_AABBCCDD, 32'h0000_1000, 32'h1122_3344};
        vecs[1] = '{32'h0000_1000, 1'b0, 64'h0,                 32'h0,         32'hAABB_CCDD};
        vecs[2] = '{32'h0000_1800, 1'b1, 64'h55667788_99AABBCC, 32'h0000_1800, 32'h99AA_BBCC};
        vecs[3] = '{32'h0000_1804, 1'b0, 64'h0,                 32'h0,         32'h5566_7788};
        vecs[4] = '{32'h0000_1000, 1'b1, 64'h11223344_AABBCCDD, 32'h0000_1000, 32'hAABB_CCDD};
        vecs[5] = '{32'h0000_0008, 1'b1, 64'hCAFEF00D_DEADBEEF, 32'h0000_0008, 32'hDEAD_BEEF};
        vecs[6] = '{32'h0000_1004, 1'b0, 64'h0,                 32'h0,         32'h1122_3344};
        vecs[7] = '{32'h0000_000C, 1'b0, 64'h0,                 32'h0,         32'hCAFE_F00D};
        vecs[8] = '{32'hFFFF_FFFC, 1'b1, 64'h0BADC0DE_12345678, 32'hFFFF_FFF8, 32'h0BAD_C0DE};
        vecs[9] = '{32'hFFFF_FFF8, 1'b0, 64'h0,                 32'h0,         32'h1234_5678};

        Sys_rst    = 1'b0;
        Sys_rdy    = 1'b1;
        Clear      = 1'b0;
        IFIC_en    = 1'b0;
        IFIC_addr  = '0;
        MCIC_en    = 1'b0;
        MCIC_block = '0;
        step();
        step();
        check("rst ICIF_en",   {31'd0, ICIF_en}, 32'd0);
        check("rst ICIF_inst", ICIF_inst, 32'd0);
        check("rst ICMC_en",   {31'd0, ICMC_en}, 32'd0);
        check("rst ICMC_addr", ICMC_addr, 32'd0);
        Sys_rst = 1'b1;
        step();

        for (int i = 0; i < 10; i++) begin
            fetch($sformatf("vec%0d", i), vecs[i]);
        end

        // Clear during a miss: fill completes silently, then the line hits.
        IFIC_addr = 32'h0000_2000;
        IFIC_en   = 1'b1;
        step();
        check("clr req_addr", ICMC_addr, 32'h0000_2000);
        IFIC_en = 1'b0;
        Clear   = 1'b1;
        step();
        Clear = 1'b0;
        check("clr still_req", {31'd0, ICMC_en}, 32'd1);
        MCIC_block = 64'h0F0F0F0F_F0F0F0F0;
        MCIC_en    = 1'b1;
        step();
        MCIC_en = 1'b0;
        check("clr no_ans", {31'd0, ICIF_en}, 32'd0);
        check("clr req_off", {31'd0, ICMC_en}, 32'd0);
        step();
        check("clr no_ans2", {31'd0, ICIF_en}, 32'd0);
        fetch("clr_hit", '{32'h0000_2004, 1'b0, 64'h0, 32'h0, 32'h0F0F_0F0F});

        // Clear on the same edge as the fill.
        IFIC_addr = 32'h0000_3000;
        IFIC_en   = 1'b1;
        step();
        check("clrmc req_addr", ICMC_addr, 32'h0000_3000);
        IFIC_en    = 1'b0;
        Clear      = 1'b1;
        MCIC_block = 64'h77777777_66666666;
        MCIC_en    = 1'b1;
        step();
        Clear   = 1'b0;
        MCIC_en = 1'b0;
        check("clrmc no_ans", {31'd0, ICIF_en}, 32'd0);
        check("clrmc req_off", {31'd0, ICMC_en}, 32'd0);
        fetch("clrmc_hit", '{32'h0000_3000, 1'b0, 64'h0, 32'h0, 32'h6666_6666});

        // Sys_rdy low during a miss freezes everything, including the answer pulse.
        IFIC_addr = 32'h0000_4008;
        IFIC_en   = 1'b1;
        step();
        check("rdy req_addr", ICMC_addr, 32'h0000_4008);
        Sys_rdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check($sformatf("rdy hold_en%0d", i),   {31'd0, ICMC_en}, 32'd1);
            check($sformatf("rdy hold_addr%0d", i), ICMC_addr, 32'h0000_4008);
            check($sformatf("rdy no_ans%0d", i),    {31'd0, ICIF_en}, 32'd0);
        end
        Sys_rdy    = 1'b1;
        MCIC_block = 64'h4444_4444_3333_3333;
        MCIC_en    = 1'b1;
        step();
        MCIC_en = 1'b0;
        check("rdy ans_en",   {31'd0, ICIF_en}, 32'd1);
        check("rdy ans_inst", ICIF_inst, 32'h3333_3333);
        IFIC_en = 1'b0;
        Sys_rdy = 1'b0;
        step();
        check("rdy pulse_frozen", {31'd0, ICIF_en}, 32'd1);
        Sys_rdy = 1'b1;
        step();
        check("rdy pulse_end", {31'd0, ICIF_en}, 32'd0);

        // Asynchronous reset in the middle of a miss.
        IFIC_addr = 32'h0000_5000;
        IFIC_en   = 1'b1;
        step();
        check("arst req_en", {31'd0, ICMC_en}, 32'd1);
        IFIC_en = 1'b0;
        #2;
        Sys_rst = 1'b0;
        #1;
        check("arst ICMC_en",   {31'd0, ICMC_en}, 32'd0);
        check("arst ICMC_addr", ICMC_addr, 32'd0);
        check("arst ICIF_en",   {31'd0, ICIF_en}, 32'd0);
        step();
        Sys_rst = 1'b1;
        step();
        fetch("arst_cold", '{32'h0000_1000, 1'b1, 64'h11223344_AABBCCDD, 32'h0000_1000, 32'hAABB_CCDD});
        fetch("arst_cold2", '{32'h0000_0008, 1'b1, 64'h01020304_05060708, 32'h0000_0008, 32'h0506_0708});

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
